param_fir_filter: RTL and testbench



---
 rtl/fir_pkg.sv | 17 +
 rtl/sync_edge.sv | 22 ++
 rtl/param_fir_filter.sv | 175 +++++++++++++++++
 tb/tb_param_fir_filter.sv | 398 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fir_pkg.sv
// Shared types and Q1.15 constants for the parameterised FIR filter.
package fir_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    SHIFT,
    MAC,
    DONE
  } fir_state_e;

  localparam logic [15:0] ONE     = 16'h8000;
  localparam logic [15:0] HALF    = 16'h4000;
  localparam logic [15:0] QUARTER = 16'h2000;
  localparam logic [15:0] EIGHTH  = 16'h1000;

endpackage

// File: rtl/sync_edge.sv
// Two-flop synchronizer followed by a single-cycle rising-edge pulse.
module sync_edge (
  input  logic clk,
  input  logic n_reset,
  input  logic async_i,
  output logic edge_o
);

  // [0],[1] are the synchronizer stages, [2] remembers the previous synced level.
  logic [2:0] sync_q;

  always_ff @(posedge clk) begin
    if (!n_reset) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[1:0], async_i};
    end
  end

  assign edge_o = sync_q[1] & ~sync_q[2];

endmodule

// File: rtl/param_fir_filter.sv
// Sequential FIR filter: one shared multiplier walks the taps, result is
// scaled from Q1.(DATA_W-1), range-checked and either clamped or truncated.
module param_fir_filter
  import fir_pkg::*;
#(
  parameter int                  NUM_TAPS    = 4,
  parameter int                  DATA_W      = 16,
  parameter logic [NUM_TAPS-1:0] TAP_SIGN    = 4'b1010,
  parameter int                  SAT_MODE    = 1,
  parameter int                  COUNT_LIMIT = 1000
) (
  input  logic              clk,
  input  logic              n_reset,
  input  logic [DATA_W-1:0] sample_data,
  input  logic [DATA_W-1:0] fir_coefficient,
  input  logic              data_ready,
  input  logic              load_coeff,
  output logic              modwait,
  output logic [DATA_W-1:0] fir_out,
  output logic              err,
  output logic              count_reached,
  output logic              coeffs_valid
);

  localparam int ACC_W = 2 * DATA_W + $clog2(NUM_TAPS) + 1;
  localparam int IDX_W = $clog2(NUM_TAPS);
  localparam int CNT_W = $clog2(COUNT_LIMIT + 1);

  // data_ready / load_coeff are level strobes from another domain; only the
  // synchronized rising edge starts work, and only while the FSM is in IDLE.
  logic data_edge;
  logic load_edge;

  sync_edge u_sync_data (
    .clk     (clk),
    .n_reset (n_reset),
    .async_i (data_ready),
    .edge_o  (data_edge)
  );

  sync_edge u_sync_load (
    .clk     (clk),
    .n_reset (n_reset),
    .async_i (load_coeff),
    .edge_o  (load_edge)
  );

  fir_state_e               state_q;
  logic [DATA_W-1:0]        coeff_q [NUM_TAPS];
  logic [DATA_W-1:0]        line_q  [NUM_TAPS];
  logic signed [ACC_W-1:0]  acc_q;
  logic [IDX_W-1:0]         tap_q;
  logic [IDX_W-1:0]         load_idx_q;
  logic [CNT_W-1:0]         cnt_q;
  logic                     modwait_q;
  logic [DATA_W-1:0]        fir_out_q;
  logic                     err_q;
  logic                     count_reached_q;
  logic                     coeffs_valid_q;

  // Single shared multiplier; operands are muxed by the current tap index.
  logic [2*DATA_W-1:0]      prod;
  logic signed [ACC_W-1:0]  prod_ext;
  logic signed [ACC_W-1:0]  acc_d;

  assign prod     = {{DATA_W{1'b0}}, line_q[tap_q]} * {{DATA_W{1'b0}}, coeff_q[tap_q]};
  assign prod_ext = {{(ACC_W - 2 * DATA_W){1'b0}}, prod};
  assign acc_d    = TAP_SIGN[tap_q] ? (acc_q - prod_ext) : (acc_q + prod_ext);

  logic signed [ACC_W-1:0]  r;
  logic                     r_neg;
  logic                     r_big;
  logic [DATA_W-1:0]        fir_out_d;
  logic                     err_d;

  assign r     = acc_q >>> (DATA_W - 1);
  assign r_neg = r[ACC_W-1];
  assign r_big = ~r_neg & (|r[ACC_W-2:DATA_W]);
  assign err_d = r_neg | r_big;

  always_comb begin
    fir_out_d = r[DATA_W-1:0];
    if (SAT_MODE != 0) begin
      if (r_neg) begin
        fir_out_d = '0;
      end else if (r_big) begin
        fir_out_d = '1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!n_reset) begin
      state_q         <= IDLE;
      acc_q           <= '0;
      tap_q           <= '0;
      load_idx_q      <= '0;
      cnt_q           <= '0;
      modwait_q       <= 1'b0;
      fir_out_q       <= '0;
      err_q           <= 1'b0;
      count_reached_q <= 1'b0;
      coeffs_valid_q  <= 1'b0;
      for (int k = 0; k < NUM_TAPS; k++) begin
        coeff_q[k] <= '0;
        line_q[k]  <= '0;
      end
    end else begin
      count_reached_q <= 1'b0;
      case (state_q)
        IDLE: begin
          // load_coeff has priority; a simultaneous data edge is dropped.
          if (load_edge) begin
            state_q   <= LOAD;
            modwait_q <= 1'b1;
          end else if (data_edge) begin
            state_q   <= SHIFT;
            modwait_q <= 1'b1;
          end
        end
        LOAD: begin
          coeff_q[load_idx_q] <= fir_coefficient;
          if (load_idx_q == IDX_W'(NUM_TAPS - 1)) begin
            load_idx_q     <= '0;
            coeffs_valid_q <= 1'b1;
          end else begin
            load_idx_q <= load_idx_q + IDX_W'(1);
          end
          state_q   <= IDLE;
          modwait_q <= 1'b0;
        end
        SHIFT: begin
          line_q[0] <= sample_data;
          for (int k = 1; k < NUM_TAPS; k++) begin
            line_q[k] <= line_q[k-1];
          end
          acc_q   <= '0;
          tap_q   <= '0;
          state_q <= MAC;
        end
        MAC: begin
          acc_q <= acc_d;
          if (tap_q == IDX_W'(NUM_TAPS - 1)) begin
            state_q <= DONE;
          end else begin
            tap_q <= tap_q + IDX_W'(1);
          end
        end
        DONE: begin
          fir_out_q <= fir_out_d;
          err_q     <= err_d;
          if (cnt_q == CNT_W'(COUNT_LIMIT - 1)) begin
            cnt_q           <= '0;
            count_reached_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
          state_q   <= IDLE;
          modwait_q <= 1'b0;
        end
        default: begin
          state_q   <= IDLE;
          modwait_q <= 1'b0;
        end
      endcase
    end
  end

  assign modwait       = modwait_q;
  assign fir_out       = fir_out_q;
  assign err           = err_q;
  assign count_reached = count_reached_q;
  assign coeffs_valid  = coeffs_valid_q;

endmodule

// File: tb/tb_param_fir_filter.sv
// Bench for param_fir_filter: four instances (both sign patterns x both
// saturation modes) share one stimulus stream; a shadow model feeds exp_q.
module tb_param_fir_filter;
  import fir_pkg::*;

  localparam int DW = 16;
  localparam int EW = DW + 1;
  localparam int W  = 4 * EW;

  logic          clk = 1'b0;
  logic          n_reset;
  logic [DW-1:0] sample_data;
  logic [DW-1:0] fir_coefficient;
  logic          data_ready;
  logic          load_coeff;
  logic [3:0]    modwait;
  logic [3:0]    err;
  logic [3:0]    count_reached;
  logic [3:0]    coeffs_valid;
  logic [DW-1:0] fir_out [4];

  int n_checks = 0;
  int n_fail   = 0;
  logic [W-1:0] exp_q[$];
  int cr_total [4] = '{0, 0, 0, 0};

  // Clock / reset block
  always #5 clk = ~clk;

  param_fir_filter #(.SAT_MODE(1)) u_a (
    .clk(clk), .n_reset(n_reset), .sample_data(sample_data), .fir_coefficient(fir_coefficient),
    .data_ready(data_ready), .load_coeff(load_coeff), .modwait(modwait[0]), .fir_out(fir_out[0]),
    .err(err[0]), .count_reached(count_reached[0]), .coeffs_valid(coeffs_valid[0]));
  param_fir_filter #(.SAT_MODE(0)) u_b (
    .clk(clk), .n_reset(n_reset), .sample_data(sample_data), .fir_coefficient(fir_coefficient),
    .data_ready(data_ready), .load_coeff(load_coeff), .modwait(modwait[1]), .fir_out(fir_out[1]),
    .err(err[1]), .count_reached(count_reached[1]), .coeffs_valid(coeffs_valid[1]));
  param_fir_filter #(.TAP_SIGN(4'b0000), .SAT_MODE(1)) u_c (
    .clk(clk), .n_reset(n_reset), .sample_data(sample_data), .fir_coefficient(fir_coefficient),
    .data_ready(data_ready), .load_coeff(load_coeff), .modwait(modwait[2]), .fir_out(fir_out[2]),
    .err(err[2]), .count_reached(count_reached[2]), .coeffs_valid(coeffs_valid[2]));
  param_fir_filter #(.TAP_SIGN(4'b0000), .SAT_MODE(0)) u_d (
    .clk(clk), .n_reset(n_reset), .sample_data(sample_data), .fir_coefficient(fir_coefficient),
    .data_ready(data_ready), .load_coeff(load_coeff), .modwait(modwait[3]), .fir_out(fir_out[3]),
    .err(err[3]), .count_reached(count_reached[3]), .coeffs_valid(coeffs_valid[3]));

  always @(negedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (count_reached[i]) cr_total[i]++;
    end
  end

  // Shadow model of coefficients and delay line
  int m_coeff [4];
  int m_line  [4];
  int m_idx;

  function automatic void model_reset();
    for (int k = 0; k < 4; k++) begin
      m_coeff[k] = 0;
      m_line[k]  = 0;
    end
    m_idx = 0;
  endfunction

  function automatic void model_load(input logic [DW-1:0] v);
    m_coeff[m_idx] = int'(v);
    m_idx = (m_idx + 1) % 4;
  endfunction

  function automatic void model_shift(input logic [DW-1:0] v);
    for (int k = 3; k > 0; k--) m_line[k] = m_line[k-1];
    m_line[0] = int'(v);
  endfunction

  function automatic logic [EW-1:0] model_out(input logic [3:0] sign, input bit sat);
    longint acc;
    longint p;
    longint r;
    logic [63:0] rb;
    acc = 0;
    for (int k = 0; k < 4; k++) begin
      p = longint'(m_line[k]) * longint'(m_coeff[k]);
      acc = sign[k] ? acc - p : acc + p;
    end
    r  = acc >>> 15;
    rb = r;
    if (r < 0)     return {1'b1, sat ? 16'h0000 : rb[15:0]};
    if (r > 65535) return {1'b1, sat ? 16'hFFFF : rb[15:0]};
    return {1'b0, rb[15:0]};
  endfunction

  function automatic logic [W-1:0] pack4(input logic [EW-1:0] a, input logic [EW-1:0] b,
                                         input logic [EW-1:0] c, input logic [EW-1:0] d);
    return {d, c, b, a};
  endfunction

  function automatic logic [W-1:0] model_all();
    return pack4(model_out(4'b1010, 1'b1), model_out(4'b1010, 1'b0),
                 model_out(4'b0000, 1'b1), model_out(4'b0000, 1'b0));
  endfunction

  // Driver tasks (entered and left on a falling clock edge)
  task automatic do_reset();
    n_reset = 1'b0; data_ready = 1'b0; load_coeff = 1'b0;
    repeat (2) @(negedge clk);
    n_reset = 1'b1;
    model_reset();
    repeat (2) @(negedge clk);
  endtask

  task automatic drive_coeff(input logic [DW-1:0] v, output bit to);
    int n;
    fir_coefficient = v;
    load_coeff = 1'b1;
    n = 0;
    while (!modwait[0] && n < 10) begin @(negedge clk); n++; end
    while (modwait[0] && n < 20) begin @(negedge clk); n++; end
    to = (n >= 20) || (n < 2);
    load_coeff = 1'b0;
    repeat (3) @(negedge clk);
    model_load(v);
  endtask

  task automatic drive_sample(input logic [DW-1:0] v, input bit poke_load,
                              output int lat, output int hi, output bit to, output logic [3:0] cr);
    sample_data = v;
    data_ready = 1'b1;
    model_shift(v);
    lat = 0; hi = 0;
    while (!modwait[0] && lat < 10) begin @(posedge clk); lat++; @(negedge clk); end
    if (poke_load) load_coeff = 1'b1;
    while (modwait[0] && hi < 30) begin hi++; @(negedge clk); end
    cr = count_reached;
    to = (lat >= 10) || (hi >= 30);
    data_ready = 1'b0;
    load_coeff = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  // Tests
  task automatic test_reset();
    n_reset = 1'b0; data_ready = 1'b0; load_coeff = 1'b0;
    sample_data = '0; fir_coefficient = '0;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if ({modwait[i], err[i], count_reached[i], coeffs_valid[i], fir_out[i]} !== 20'h0) begin
        n_fail++;
        $display("FAIL reset dut%0d: mw=%0b err=%0b cr=%0b cv=%0b out=%0d, required all 0",
                 i, modwait[i], err[i], count_reached[i], coeffs_valid[i], fir_out[i]);
      end
    end
    n_reset = 1'b1;
    model_reset();
    repeat (2) @(negedge clk);
  endtask

  task automatic test_ref_vectors();
    logic [DW-1:0] cf [4] = '{HALF, ONE, ONE, HALF};
    logic [EW-1:0] ea [4] = '{17'd50, {1'b1, 16'd0},     17'd50,  17'd0};
    logic [EW-1:0] eb [4] = '{17'd50, {1'b1, 16'd65486}, 17'd50,  17'd0};
    logic [EW-1:0] ec [4] = '{17'd50, 17'd150,           17'd250, 17'd300};
    logic [W-1:0] exp;
    logic [3:0] cr;
    int lat, hi;
    bit to;
    do_reset();
    for (int k = 0; k < 4; k++) begin
      drive_coeff(cf[k], to);
      n_checks++;
      if (to) begin n_fail++; $display("FAIL ref_load%0d: load handshake timed out", k); end
      if (k == 2) begin
        n_checks++;
        if (coeffs_valid !== 4'b0000) begin
          n_fail++; $display("FAIL ref_cv_early: coeffs_valid=%b, required 0000", coeffs_valid);
        end
      end
    end
    n_checks++;
    if (coeffs_valid !== 4'b1111) begin
      n_fail++; $display("FAIL ref_cv_set: coeffs_valid=%b, required 1111", coeffs_valid);
    end
    for (int s = 0; s < 4; s++) begin
      exp_q.push_back(pack4(ea[s], eb[s], ec[s], ec[s]));
      drive_sample(16'd100, 1'b0, lat, hi, to, cr);
      if (s == 0) begin
        n_checks++;
        if (lat != 3 || hi != 6 || to) begin
          n_fail++; $display("FAIL ref_timing: rise=%0d high=%0d to=%0b, required rise=3 high=6", lat, hi, to);
        end
      end
      exp = exp_q.pop_front();
      for (int i = 0; i < 4; i++) begin
        n_checks++;
        if ({err[i], fir_out[i]} !== exp[i*EW +: EW]) begin
          n_fail++;
          $display("FAIL ref_vec s%0d dut%0d: err=%0b out=%0d, required err=%0b out=%0d",
                   s, i, err[i], fir_out[i], exp[i*EW+DW], exp[i*EW +: DW]);
        end
      end
    end
  endtask

  task automatic test_saturation();
    logic [EW-1:0] ea [2] = '{17'd65000, 17'd0};
    logic [EW-1:0] ec [2] = '{17'd65000, {1'b1, 16'd65535}};
    logic [EW-1:0] ed [2] = '{17'd65000, {1'b1, 16'd64464}};
    logic [W-1:0] exp;
    logic [3:0] cr;
    int lat, hi;
    bit to;
    do_reset();
    for (int k = 0; k < 4; k++) drive_coeff(ONE, to);
    for (int s = 0; s < 2; s++) begin
      exp_q.push_back(pack4(ea[s], ea[s], ec[s], ed[s]));
      drive_sample(16'd65000, 1'b0, lat, hi, to, cr);
      exp = exp_q.pop_front();
      for (int i = 0; i < 4; i++) begin
        n_checks++;
        if ({err[i], fir_out[i]} !== exp[i*EW +: EW]) begin
          n_fail++;
          $display("FAIL sat s%0d dut%0d: err=%0b out=%0d, required err=%0b out=%0d",
                   s, i, err[i], fir_out[i], exp[i*EW+DW], exp[i*EW +: DW]);
        end
      end
    end
  endtask

  task automatic test_collision();
    logic [W-1:0] exp;
    logic [3:0] cr;
    int lat, hi, busy;
    bit to;
    do_reset();
    fir_coefficient = HALF; sample_data = 16'd999;
    load_coeff = 1'b1; data_ready = 1'b1;
    busy = 0;
    repeat (20) begin @(negedge clk); if (modwait[0]) busy++; end
    n_checks++;
    if (busy != 1 || fir_out[0] !== 16'd0) begin
      n_fail++; $display("FAIL collide_one_load: busy=%0d out=%0d, required busy=1 out=0", busy, fir_out[0]);
    end
    load_coeff = 1'b0; data_ready = 1'b0;
    repeat (3) @(negedge clk);
    model_load(HALF);
    drive_coeff(ONE, to);
    drive_coeff(ONE, to);
    exp_q.push_back(0);
    exp_q.pop_front();
    exp_q.push_back(0);
    exp_q.delete();
    drive_sample(16'd200, 1'b1, lat, hi, to, cr);
    exp_q.push_back(model_all());
    busy = 0;
    repeat (6) begin @(negedge clk); if (modwait[0]) busy++; end
    n_checks++;
    if (hi != 6 || busy != 0 || coeffs_valid !== 4'b0000) begin
      n_fail++;
      $display("FAIL mac_load_ignored: high=%0d extra=%0d cv=%b, required 6 0 0000", hi, busy, coeffs_valid);
    end
    exp = exp_q.pop_front();
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if ({err[i], fir_out[i]} !== exp[i*EW +: EW]) begin
        n_fail++;
        $display("FAIL collide_res dut%0d: err=%0b out=%0d, required err=%0b out=%0d",
                 i, err[i], fir_out[i], exp[i*EW+DW], exp[i*EW +: DW]);
      end
    end
    drive_coeff(QUARTER, to);
    n_checks++;
    if (coeffs_valid !== 4'b1111) begin
      n_fail++; $display("FAIL collide_cv: coeffs_valid=%b after 4 loads, required 1111", coeffs_valid);
    end
    drive_sample(16'd300, 1'b0, lat, hi, to, cr);
    exp_q.push_back(model_all());
    exp = exp_q.pop_front();
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if ({err[i], fir_out[i]} !== exp[i*EW +: EW]) begin
        n_fail++;
        $display("FAIL collide_res2 dut%0d: err=%0b out=%0d, required err=%0b out=%0d",
                 i, err[i], fir_out[i], exp[i*EW+DW], exp[i*EW +: DW]);
      end
    end
  endtask

  task automatic test_random();
    logic [W-1:0] exp;
    logic [3:0] cr;
    int lat, hi;
    bit to;
    do_reset();
    for (int k = 0; k < 4; k++) drive_coeff(DW'($urandom_range(0, 16'h9000)), to);
    for (int s = 0; s < 10; s++) begin
      drive_sample(DW'($urandom_range(0, 16'hFFFF)), 1'b0, lat, hi, to, cr);
      exp_q.push_back(model_all());
      exp = exp_q.pop_front();
      for (int i = 0; i < 4; i++) begin
        n_checks++;
        if ({err[i], fir_out[i]} !== exp[i*EW +: EW] || to) begin
          n_fail++;
          $display("FAIL rand s%0d dut%0d: err=%0b out=%0d to=%0b, required err=%0b out=%0d",
                   s, i, err[i], fir_out[i], to, exp[i*EW+DW], exp[i*EW +: DW]);
        end
      end
    end
  endtask

  task automatic test_reset_mid_mac();
    logic [W-1:0] exp;
    logic [3:0] cr;
    int lat, hi, n;
    bit to;
    sample_data = 16'd1234;
    data_ready = 1'b1;
    n = 0;
    while (!modwait[0] && n < 10) begin @(negedge clk); n++; end
    repeat (2) @(negedge clk);
    n_reset = 1'b0;
    data_ready = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if ({modwait[i], err[i], coeffs_valid[i], fir_out[i]} !== 19'h0) begin
        n_fail++;
        $display("FAIL midmac_reset dut%0d: mw=%0b err=%0b cv=%0b out=%0d, required all 0",
                 i, modwait[i], err[i], coeffs_valid[i], fir_out[i]);
      end
    end
    n_reset = 1'b1;
    model_reset();
    repeat (3) @(negedge clk);
    exp_q.push_back('0);
    drive_sample(16'd777, 1'b0, lat, hi, to, cr);
    exp = exp_q.pop_front();
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if ({err[i], fir_out[i]} !== exp[i*EW +: EW] || to) begin
        n_fail++;
        $display("FAIL midmac_after dut%0d: err=%0b out=%0d to=%0b, required err=0 out=0",
                 i, err[i], fir_out[i], to);
      end
    end
  endtask

  task automatic test_count();
    logic [W-1:0] exp;
    logic [3:0] cr;
    int lat, hi;
    bit to;
    bit bad_out;
    int pulse_at [4];
    int base [4];
    do_reset();
    bad_out = 1'b0;
    for (int i = 0; i < 4; i++) begin pulse_at[i] = -1; base[i] = cr_total[i]; end
    for (int n = 1; n <= 1002; n++) begin
      exp_q.push_back('0);
      drive_sample(16'd0, 1'b0, lat, hi, to, cr);
      exp = exp_q.pop_front();
      for (int i = 0; i < 4; i++) begin
        if (cr[i]) pulse_at[i] = n;
        if ({err[i], fir_out[i]} !== exp[i*EW +: EW] || to) bad_out = 1'b1;
      end
    end
    n_checks++;
    if (bad_out) begin n_fail++; $display("FAIL count_outputs: nonzero out/err or timeout seen, required 0"); end
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (pulse_at[i] != 1000 || cr_total[i] - base[i] != 1) begin
        n_fail++;
        $display("FAIL count_pulse dut%0d: after sample %0d, pulses=%0d, required sample 1000 pulses=1",
                 i, pulse_at[i], cr_total[i] - base[i]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_ref_vectors();
    test_saturation();
    test_collision();
    test_random();
    test_reset_mid_mac();
    test_count();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    repeat (60000) @(posedge clk);
    $display("FAIL watchdog: cycle budget expired after %0d checks, %0d failures", n_checks, n_fail);
    $fatal(1, "watchdog");
  end

endmodule
